// File: rtl/cdb_scheduler_pkg.sv
// cdb_scheduler_pkg: shared constants and helpers for the common-data-bus scheduler.
package cdb_scheduler_pkg;
   localparam int CDB_IDLE_SEL    = 0;
   localparam int CDB_ADDR_ALU    = 1;
   localparam int CDB_ADDR_BRANCH = 2;
   localparam int CDB_ADDR_MULDIV = 3;
   localparam int CDB_ADDR_LS     = 4;

   function automatic int cdb_wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction
endpackage

// File: rtl/cdb_scheduler_rr_pick.sv
// cdb_scheduler_rr_pick: cyclic first-one finder starting at i_start.
module cdb_scheduler_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_start,
   output logic          o_valid,
   output logic [IW-1:0] o_idx
);
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      // Scan farthest-first so the nearest hit from i_start wins last.
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[IW'((int'(i_start) + k) % N)]) begin
            o_valid = 1'b1;
            o_idx   = IW'((int'(i_start) + k) % N);
         end
      end
   end
endmodule

// File: rtl/cdb_scheduler.sv
// cdb_scheduler: round-robin owner select for two shared result buses.
// Define CDB_PERF_EN to add the perf_full / perf_stall counters.
module cdb_scheduler
   import cdb_scheduler_pkg::*;
#(
   parameter int REQUESTERS = 4,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_clear,
   input  logic [REQUESTERS-1:0] i_req,
   output logic [ADDR_WIDTH-1:0] o_select1,
   output logic [ADDR_WIDTH-1:0] o_select2,
   output logic [REQUESTERS-1:0] o_grant1,
   output logic [REQUESTERS-1:0] o_grant2
`ifdef CDB_PERF_EN
   ,
   output logic [31:0]           o_perf_full,
   output logic [31:0]           o_perf_stall
`endif
);
   localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   logic [IW-1:0]         r_ptr;
   logic [ADDR_WIDTH-1:0] r_sel1, r_sel2;
   logic [REQUESTERS-1:0] w_grant1, w_grant2, w_eff, w_req2;
   logic                  w_v1, w_v2;
   logic [IW-1:0]         w_idx1, w_idx2, w_start2, w_ptr_nxt;
   logic [ADDR_WIDTH-1:0] w_nsel1, w_nsel2;

   always_comb begin
      w_grant1 = '0;
      w_grant2 = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         w_grant1[i] = (r_sel1 == ADDR_WIDTH'(i + 1));
         w_grant2[i] = (r_sel2 == ADDR_WIDTH'(i + 1));
      end
   end

   // Current bus owners are still dropping req this cycle; ignore them.
   assign w_eff = i_req & ~(w_grant1 | w_grant2);

   cdb_scheduler_rr_pick #(.N(REQUESTERS), .IW(IW)) u_pick1 (
      .i_req   (w_eff),
      .i_start (r_ptr),
      .o_valid (w_v1),
      .o_idx   (w_idx1)
   );

   always_comb begin
      w_req2         = w_eff;
      w_req2[w_idx1] = 1'b0;
   end

   assign w_start2 = IW'(cdb_wrap_inc(int'(w_idx1), REQUESTERS));

   cdb_scheduler_rr_pick #(.N(REQUESTERS), .IW(IW)) u_pick2 (
      .i_req   (w_req2),
      .i_start (w_start2),
      .o_valid (w_v2),
      .o_idx   (w_idx2)
   );

   assign w_nsel1   = w_v1 ? ADDR_WIDTH'(w_idx1) + ADDR_WIDTH'(1) : ADDR_WIDTH'(CDB_IDLE_SEL);
   assign w_nsel2   = w_v2 ? ADDR_WIDTH'(w_idx2) + ADDR_WIDTH'(1) : ADDR_WIDTH'(CDB_IDLE_SEL);
   assign w_ptr_nxt = !w_v1 ? r_ptr
                    : IW'(cdb_wrap_inc(int'(w_v2 ? w_idx2 : w_idx1), REQUESTERS));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ptr  <= '0;
         r_sel1 <= ADDR_WIDTH'(CDB_IDLE_SEL);
         r_sel2 <= ADDR_WIDTH'(CDB_IDLE_SEL);
      end else if (i_clear) begin
         r_sel1 <= ADDR_WIDTH'(CDB_IDLE_SEL);
         r_sel2 <= ADDR_WIDTH'(CDB_IDLE_SEL);
      end else begin
         r_ptr  <= w_ptr_nxt;
         r_sel1 <= w_nsel1;
         r_sel2 <= w_nsel2;
      end
   end

   assign o_select1 = r_sel1;
   assign o_select2 = r_sel2;
   assign o_grant1  = w_grant1;
   assign o_grant2  = w_grant2;

`ifdef CDB_PERF_EN
   logic [31:0]           r_full, r_stall;
   logic [REQUESTERS-1:0] w_served;

   // A flush cancels this edge's picks, so every effective request goes unserved.
   always_comb begin
      w_served = '0;
      if (!i_clear && w_v1) w_served[w_idx1] = 1'b1;
      if (!i_clear && w_v2) w_served[w_idx2] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_full  <= '0;
         r_stall <= '0;
      end else begin
         r_full  <= r_full + 32'((r_sel1 != '0) && (r_sel2 != '0));
         r_stall <= r_stall + 32'(|(w_eff & ~w_served));
      end
   end

   assign o_perf_full  = r_full;
   assign o_perf_stall = r_stall;
`endif
endmodule
